// File: rtl/match_logger.sv
// Match logger: timestamps each accepted hit pulse into a small show-ahead FIFO,
// keeps a saturating hit counter and a sticky overflow flag for dropped hits.
module match_logger #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TS_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    hit,
   input  logic                    clear,
   input  logic                    rd_en,
   output logic [TS_W-1:0]         rd_data,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level,
   output logic [7:0]              match_cnt,
   output logic                    overflow
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

   logic [TS_W-1:0] ts_q, ts_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [7:0]      match_cnt_q, match_cnt_d;
   logic            overflow_q, overflow_d;
   logic [TS_W-1:0] mem_q [DEPTH];

   logic full_c, empty_c, push, pop, mem_we;

   // Next-state: clear wins over hit/rd_en; a pop frees a slot for a same-cycle push.
   always_comb begin
      full_c      = (count_q == DepthC);
      empty_c     = (count_q == '0);
      pop         = rd_en && !empty_c;
      push        = hit && (!full_c || pop);
      ts_d        = ts_q + TS_W'(1);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      match_cnt_d = match_cnt_q;
      overflow_d  = overflow_q;
      mem_we      = 1'b0;
      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         match_cnt_d = '0;
         overflow_d  = 1'b0;
      end else begin
         mem_we = push;
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
         end
         if (hit && (match_cnt_q != 8'hFF)) begin
            match_cnt_d = match_cnt_q + 8'd1;
         end
         // Hit lost only when full and nothing leaves this cycle.
         if (hit && full_c && !pop) begin
            overflow_d = 1'b1;
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         match_cnt_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         ts_q        <= ts_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         match_cnt_q <= match_cnt_d;
         overflow_q  <= overflow_d;
      end
   end

   // Entry storage; contents are meaningless once the pointers are reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[wr_ptr_q] <= ts_q;
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == DepthC);
   assign level     = count_q;
   assign match_cnt = match_cnt_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_match_logger.sv
// Bench for match_logger: directed stimulus, queue scoreboard checked by a pop monitor.
module tb_match_logger;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TS_W  = 16;

   logic                   clk = 1'b0;
   logic                   reset, hit, clear, rd_en;
   logic [TS_W-1:0]        rd_data;
   logic                   empty, full, overflow;
   logic [$clog2(DEPTH):0] level;
   logic [7:0]             match_cnt;

   int n_checks = 0;
   int n_err    = 0;

   logic [TS_W-1:0] sb_q [$];
   logic [TS_W-1:0] ref_ts;

   match_logger #(
      .DEPTH (DEPTH),
      .TS_W  (TS_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hit       (hit),
      .clear     (clear),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .level     (level),
      .match_cnt (match_cnt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Reference timestamp: free-running, zeroed by reset.
   always @(posedge clk) ref_ts <= reset ? '0 : ref_ts + TS_W'(1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every real pop must return the oldest expected timestamp.
   always @(negedge clk) begin
      if (!reset && !clear && rd_en && !empty) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL pop_unexpected: got %0d expected no entry at %0t", rd_data, $time);
         end else begin
            check("pop_data", rd_data, sb_q.pop_front());
         end
      end
   end

   // One clock of stimulus; logged timestamps go to the scoreboard as they are issued.
   task automatic step(input logic h, input logic r, input logic c, input logic rst);
      int lvl;
      bit pop;
      reset = rst;
      hit   = h;
      rd_en = r;
      clear = c;
      if (rst || c) begin
         sb_q.delete();
      end else begin
         lvl = sb_q.size();
         pop = r && (lvl > 0);
         if (h && ((lvl < DEPTH) || pop)) sb_q.push_back(ref_ts);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      hit   = 1'b0;
      rd_en = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b1;
      hit   = 1'b0;
      clear = 1'b0;
      rd_en = 1'b0;

      // Reset state, then first hit at ts=5.
      step(0, 0, 0, 1);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_level", level, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_overflow", overflow, 0);
      repeat (5) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      check("first_empty", empty, 0);
      check("first_level", level, 1);
      check("first_rd_data", rd_data, 5);
      check("first_match_cnt", match_cnt, 1);
      step(0, 1, 0, 0);
      check("first_popped_empty", empty, 1);

      // Five hits into a four-deep FIFO with no reads.
      step(0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0);
         if (i == 3) begin
            check("fill_full", full, 1);
            check("fill_level", level, 4);
            check("fill_no_ovf", overflow, 0);
         end
         step(0, 0, 0, 0);
      end
      check("drop_overflow", overflow, 1);
      check("drop_match_cnt", match_cnt, 5);
      check("drop_level", level, 4);
      for (int i = 0; i < 4; i++) begin
         check("drain_head", rd_data, 2 + 2 * i);
         step(0, 1, 0, 0);
      end
      check("drain_empty", empty, 1);
      check("drain_ovf_sticky", overflow, 1);

      // Full FIFO with push and pop in the same cycle.
      step(0, 0, 0, 1);
      check("rst2_overflow", overflow, 0);
      repeat (4) step(1, 0, 0, 0);
      check("pp_full_before", full, 1);
      step(1, 1, 0, 0);
      check("pp_level", level, 4);
      check("pp_overflow", overflow, 0);
      check("pp_full", full, 1);
      for (int i = 0; i < 4; i++) begin
         check("pp_head", rd_data, 1 + i);
         step(0, 1, 0, 0);
      end

      // Reads on empty are ignored; hit+read on empty is push only.
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         check("rd_empty_level", level, 0);
         check("rd_empty_flag", empty, 1);
      end
      step(1, 1, 0, 0);
      check("hit_rd_empty_level", level, 1);
      step(0, 1, 0, 0);

      // Counter saturation, then clear with a simultaneous hit.
      step(0, 0, 0, 1);
      repeat (300) step(1, 0, 0, 0);
      check("sat_match_cnt", match_cnt, 255);
      check("sat_overflow", overflow, 1);
      check("sat_level", level, 4);
      step(1, 0, 1, 0);
      check("clr_match_cnt", match_cnt, 0);
      check("clr_level", level, 0);
      check("clr_overflow", overflow, 0);
      check("clr_empty", empty, 1);
      step(1, 0, 0, 0);
      check("clr_ts_continues", rd_data, 301);
      check("clr_match_after", match_cnt, 1);
      check("clr_level_after", level, 1);

      // Reset with an entry stored, then timestamp wrap.
      step(0, 0, 0, 1);
      check("midrst_empty", empty, 1);
      check("midrst_level", level, 0);
      check("midrst_match_cnt", match_cnt, 0);
      repeat (65535) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("wrap_level", level, 2);
      check("wrap_head_ffff", rd_data, 16'hFFFF);
      step(0, 1, 0, 0);
      check("wrap_head_0000", rd_data, 0);
      step(0, 1, 0, 0);
      check("wrap_empty", empty, 1);
      check("final_level", level, sb_q.size());

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
